// File: rtl/div8_shift_pkg.sv
// Shared arithmetic-unit definitions: state encoding, default operand width
// and the packing of the 2*WIDTH result bus used by both mult8 and the divider.
package div8_shift_pkg;

    // Default operand width of the arithmetic unit.
    localparam int DEF_WIDTH = 8;

    // Three-state sequencer encoding, common with mult8.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result bus field positions for the default width: {remainder, quotient}.
    localparam int REM_MSB = 2 * DEF_WIDTH - 1;
    localparam int REM_LSB = DEF_WIDTH;
    localparam int QUO_MSB = DEF_WIDTH - 1;
    localparam int QUO_LSB = 0;

endpackage

// File: rtl/div8_shift_if.sv
// Request/result bundle of the divider. The requester drives start and the
// operands; the divider returns the packed result and its status flags.
interface div8_shift_if
    import div8_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                   start;
    logic [WIDTH-1:0]       ina;
    logic [WIDTH-1:0]       inb;
    logic [2*WIDTH-1:0]     out;
    logic                   busy;
    logic                   done;
    logic                   dbz;

    modport master (
        output start, ina, inb,
        input  out, busy, done, dbz
    );

    modport slave (
        input  start, ina, inb,
        output out, busy, done, dbz
    );

endinterface

// File: rtl/div8_shift_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and emit the quotient bit.
module div8_shift_div_step
    import div8_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] r_shift;

    // Shift, compare and conditionally subtract. The incoming remainder is
    // always below the divisor, so it fits WIDTH bits; only the shifted value
    // needs the extra bit, and the difference again fits WIDTH bits, so the
    // modular WIDTH-bit subtraction is exact.
    always_comb begin
        r_shift = {r_i, q_msb_i};
        q_bit_o = (r_shift >= {1'b0, d_i});
        if (q_bit_o) begin
            r_o = r_shift[WIDTH-1:0] - d_i;
        end else begin
            r_o = r_shift[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div8_shift.sv
// Sequential restoring unsigned divider. Produces one quotient bit per clock
// over WIDTH cycles and returns {remainder, quotient} on the shared result bus.
// A zero divisor short-circuits to DONE with dbz set and {dividend, all ones}.
module div8_shift
    import div8_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          sig,
    div8_shift_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   step_r;
    logic               step_q;

    div8_shift_div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[WIDTH-1]),
        .d_i     (d_q),
        .r_o     (step_r),
        .q_bit_o (step_q)
    );

    // Next-state and datapath update; every register holds unless its state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        out_d   = out_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.inb != '0) begin
                        d_d     = bus.inb;
                        q_d     = bus.ina;
                        r_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        out_d   = {bus.ina, {WIDTH{1'b1}}};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: publish the freshly computed pair directly.
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = {step_r, q_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; sig clears everything and wins over start.
    always_ff @(posedge clk) begin
        if (sig) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.dbz  = dbz_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_div8_shift.sv
// Bench for div8_shift: directed vector table, multi-cycle corner sequences
// and a random sweep against a plain-arithmetic division model.
module tb_div8_shift;
    import div8_shift_pkg::*;

    localparam int W = 8;

    logic clk;
    logic sig;
    int   checks;
    int   errors;

    div8_shift_if #(.WIDTH(W)) bus ();

    div8_shift #(.WIDTH(W)) dut (
        .clk (clk),
        .sig (sig),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: quotient/remainder by integer arithmetic, zero divisor rule.
    function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        int qv, rv;
        if (b == 0) return {1'b1, a, 8'hFF};
        qv = int'(a) / int'(b);
        rv = int'(a) % int'(b);
        return {1'b0, 8'(rv), 8'(qv)};
    endfunction

    // Issue one request, scramble the operands after the start edge, wait
    // (bounded) for done and check timing; returns the observed result.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input string tag,
                           output logic [7:0] q, output logic [7:0] r, output logic dz);
        int n;
        bus.ina   = a;
        bus.inb   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ina   = 8'($urandom);
        bus.inb   = 8'($urandom);
        chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, " latency"}, 32'(n), (b == 0) ? 32'd0 : 32'(W));
        q  = bus.out[QUO_MSB:QUO_LSB];
        r  = bus.out[REM_MSB:REM_LSB];
        dz = bus.dbz;
        tick();
        chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_cleared"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0]  q, r, ra, rb;
        logic        dz;
        logic [16:0] m;
        int          dones;
        int          n;

        checks    = 0;
        errors    = 0;
        sig       = 1'b1;
        bus.start = 1'b0;
        bus.ina   = '0;
        bus.inb   = '0;

        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
        vecs[5] = '{a: 8'd77,  b: 8'd0,   q: 8'hFF,  r: 8'd77, dz: 1'b1};
        vecs[6] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  dz: 1'b0};
        vecs[7] = '{a: 8'd100, b: 8'd10,  q: 8'd10,  r: 8'd0,  dz: 1'b0};

        // Reset state
        tick();
        tick();
        sig = 1'b0;
        chk("reset out",  32'(bus.out),  32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset dbz",  32'(bus.dbz),  32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), q, r, dz);
            chk($sformatf("vec%0d quotient", i),  32'(q),  32'(vecs[i].q));
            chk($sformatf("vec%0d remainder", i), 32'(r),  32'(vecs[i].r));
            chk($sformatf("vec%0d dbz", i),       32'(dz), 32'(vecs[i].dz));
        end

        // Divide by zero result holds in IDLE, then a good divide clears dbz at its start
        run_div(8'd77, 8'd0, "dbz_hold", q, r, dz);
        tick();
        tick();
        chk("dbz_hold out", 32'(bus.out), 32'h4DFF);
        chk("dbz_hold flag", 32'(bus.dbz), 32'd1);
        bus.ina   = 8'd10;
        bus.inb   = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("dbz_clear_on_start", 32'(bus.dbz), 32'd0);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("after_dbz out", 32'(bus.out), {16'd0, 8'd1, 8'd3});
        tick();

        // Start while busy is ignored
        bus.ina   = 8'd100;
        bus.inb   = 8'd10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.ina   = 8'd50;
        bus.inb   = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ina   = 8'd33;
        bus.inb   = 8'd0;
        dones = 0;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("busy_start out", 32'(bus.out), {16'd0, 8'd0, 8'd10});
        chk("busy_start dbz", 32'(bus.dbz), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("busy_start extra_done", 32'(dones), 32'd0);
        chk("busy_start idle", 32'(bus.busy), 32'd0);

        // Reset during the 4th RUN cycle aborts without done
        bus.ina   = 8'd200;
        bus.inb   = 8'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        sig = 1'b1;
        tick();
        sig = 1'b0;
        chk("abort out",  32'(bus.out),  32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort dbz",  32'(bus.dbz),  32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            tick();
        end
        chk("abort no_done", 32'(dones), 32'd0);
        run_div(8'd200, 8'd7, "post_abort", q, r, dz);
        chk("post_abort out", 32'({r, q}), {16'd0, 8'd4, 8'd28});
        chk("post_abort dbz", 32'(dz), 32'd0);

        // Random sweep with nonzero divisors
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_div(ra, rb, "rnd", q, r, dz);
            m = ref_div(ra, rb);
            chk($sformatf("rnd %0d/%0d result", ra, rb), 32'({dz, r, q}), 32'(m));
            chk($sformatf("rnd %0d/%0d identity", ra, rb), 32'(int'(q) * int'(rb) + int'(r)), 32'(ra));
            chk($sformatf("rnd %0d/%0d rem_lt_div", ra, rb), 32'(r < rb), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div8_shift.md
Name: div8_shift

Overview:
- Sequential shift-subtract (restoring) unsigned divider. It is the inverse datapath of the 8-bit shift multiplier.
- Takes an 8-bit dividend and an 8-bit divisor and produces the quotient and remainder over WIDTH iteration cycles, one quotient bit per cycle.
- Sits beside mult8 in the arithmetic unit.
- Output packing mirrors mult8's 16-bit out bus, so both blocks share one result path.

Parameters:
- WIDTH, 8, operand width. The out bus is 2*WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge
- sig  input  1  synchronous active-high reset/clear
- start  input  1  request; sampled only in IDLE
- ina  input  WIDTH  dividend; sampled on the start edge
- inb  input  WIDTH  divisor; sampled on the start edge
- out  output  2*WIDTH  {remainder, quotient}; remainder in the upper half
- busy  output  1  high whenever state != IDLE
- done  output  1  single-cycle result-valid pulse
- dbz  output  1  divide-by-zero flag; valid with done

Behaviour:
- Reset:
  - Clock and reset are decided: one clock, clk; reset is synchronous and active-high (sig).
  - sig=1 at any edge forces state=IDLE and clears out, busy, done, dbz and all internal registers to 0.
  - sig has priority over start and over any in-flight operation. An aborted divide produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and inb!=0 at edge E0: latch D=inb, Q=ina, R=0 (WIDTH+1 bits), cnt=WIDTH, then go to RUN.
  - If start=1 and inb==0 at E0: go directly to DONE with out={ina, all ones}, dbz=1.
  - Otherwise remain in IDLE.
- RUN, one iteration per edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}, Q shifted left by one.
  - If R' >= D: R = R' - D and Q[0] = 1. Otherwise R = R' and Q[0] = 0.
  - cnt decrements each iteration. On the edge where cnt reaches 0 (E_WIDTH), register out={R[WIDTH-1:0], Q} and go to DONE.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE on the next edge.
- Latency:
  - Normal divide: done is high in the cycle after edge E_WIDTH+... specifically after E8 for WIDTH=8, i.e. WIDTH cycles after the start edge. busy is high from after E0 until after E9.
  - Divide by zero: done is high in the cycle immediately after E0.
- start handling: start while busy (RUN or DONE) is ignored, with no queueing. A new start is accepted on the first edge back in IDLE.
- Output hold:
  - out and dbz hold their values from DONE until the next accepted start or reset.
  - dbz clears on the next accepted start that has a nonzero divisor.
- Input stability: ina and inb may change freely after E0, because the latched copies are used.
- Arithmetic: all values are unsigned. The remainder is always < divisor. quotient*divisor + remainder == dividend for every nonzero divisor.

Decomposition:
- Shared arith package holds:
  - the state encoding constants (IDLE/RUN/DONE), reused with mult8;
  - the default WIDTH;
  - the out-packing field positions (REM_MSB/LSB, QUO_MSB/LSB).
- One natural sub-module, div_step: combinational single-iteration shift/compare/subtract taking R, Q[MSB], D and returning the new R and quotient bit.
- The top level keeps the FSM, counter and registers.

Test Plan:
- Basic divide: sig=1 for 2 cycles, then ina=200, inb=7, start pulse. Expect out={8'd4, 8'd28}, dbz=0, done high exactly 1 cycle, WIDTH cycles after the start edge.
- Extremes: 255/1 gives q=255, r=0. 5/9 gives q=0, r=5. 0/3 gives q=0, r=0. 255/255 gives q=1, r=0.
- Divide by zero: ina=77, inb=0, start. Expect done in the next cycle, dbz=1, out={8'd77, 8'hFF}, busy high for 1 cycle only. A following 10/3 returns q=3, r=1 with dbz=0.
- Start while busy: start 100/10, then pulse start with 50/5 mid-RUN and change ina/inb. Expect result q=10, r=0. Exactly one done. No second operation begins unless start is reasserted in IDLE.
- Reset mid-operation: assert sig during the 4th RUN cycle of 200/7. Expect out=0, busy=0, done never pulses. A subsequent 200/7 completes normally.
- Random sweep: 500 random pairs with nonzero divisor. Check q*d + r == a and r < d against a reference model.
